// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed BCD scan controller feeding one registered 7-segment decoder.
// Latency: seg_bcd loads on slot cycle 0; digit_en rises BLANK_CYCLES into the slot. No backpressure.
// Double-buffered display word: loads land in shadow, promoted to active only at frame boundaries.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    lz_blank,
    output logic [3:0]              seg_bcd,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]             cnt;
    logic [IW-1:0]             idx;
    logic [4*NUM_DIGITS-1:0]   shadow;
    logic [4*NUM_DIGITS-1:0]   active;
    logic                      slot_supp;

    logic                      cnt_wrap;
    logic                      frame_start;
    logic [4*NUM_DIGITS-1:0]   act_sel;
    logic [3:0]                cur_digit;
    logic                      upper_zero;
    logic [NUM_DIGITS-1:0]     one_hot;

    // cnt/idx name the slot cycle the outputs will present after the next edge,
    // so the frame boundary is the edge that loads digit 0 of a new frame.
    always_comb begin
        cnt_wrap    = (cnt == CNT_LAST);
        frame_start = (cnt == '0) && (idx == '0);
        act_sel     = active;
        if (frame_start) begin
            act_sel = load ? value : shadow;
        end
        cur_digit  = 4'h0;
        upper_zero = 1'b1;
        one_hot    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx) begin
                cur_digit  = act_sel[4*i +: 4];
                one_hot[i] = 1'b1;
            end
            if ((IW'(i) >= idx) && (act_sel[4*i +: 4] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            shadow     <= '0;
            active     <= '0;
            slot_supp  <= 1'b0;
            seg_bcd    <= 4'h0;
            digit_en   <= '0;
            frame_done <= 1'b0;
        end else begin
            if (load) begin
                shadow <= value;
            end
            active <= act_sel;

            if (cnt_wrap) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (cnt == '0) begin
                seg_bcd   <= cur_digit;
                slot_supp <= lz_blank && (idx != '0) && upper_zero;
            end

            // Blanking window hides decoder latency and ghosting between digits.
            if ((cnt < CNT_BLANK) || slot_supp) begin
                digit_en <= '0;
            end else begin
                digit_en <= one_hot;
            end

            frame_done <= cnt_wrap && (idx == IDX_LAST);
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl with 4 digits, 8-cycle slots, 2 blank cycles.
module tb_sevenseg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic        lz_blank;
    logic [3:0]  seg_bcd;
    logic [3:0]  digit_en;
    logic        frame_done;

    int total = 0;
    int bad   = 0;
    int cyc   = -1;

    sevenseg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .value     (value),
        .lz_blank  (lz_blank),
        .seg_bcd   (seg_bcd),
        .digit_en  (digit_en),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: the posedge inside samples any pending load, which is then dropped.
    task automatic tick();
        @(negedge clk);
        cyc++;
        load = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        load  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = -1;
    endtask

    // Checks every cycle up to and including frame cycle 'last'.
    // segs holds the digit shown in each slot, mask the slots whose enable asserts.
    task automatic check_frame(input string name, input logic [15:0] segs,
                               input logic [3:0] mask, input int last);
        int c;
        int s;
        int k;
        int guard;
        logic [15:0] tmp;
        logic [3:0]  e_seg;
        logic [3:0]  e_en;
        logic        e_fd;
        guard = 0;
        do begin
            tick();
            c     = cyc % 32;
            s     = c / 8;
            k     = c % 8;
            tmp   = segs >> (4 * s);
            e_seg = tmp[3:0];
            e_en  = (k >= 2 && mask[s]) ? (4'b0001 << s) : 4'b0000;
            e_fd  = (c == 31);
            total++;
            if (digit_en !== e_en) begin
                bad++;
                $display("FAIL %s digit_en cyc=%0d got=%b want=%b", name, c, digit_en, e_en);
            end
            total++;
            if (seg_bcd !== e_seg) begin
                bad++;
                $display("FAIL %s seg_bcd cyc=%0d got=%h want=%h", name, c, seg_bcd, e_seg);
            end
            total++;
            if (frame_done !== e_fd) begin
                bad++;
                $display("FAIL %s frame_done cyc=%0d got=%b want=%b", name, c, frame_done, e_fd);
            end
            guard++;
        end while (c != last && guard < 64);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (digit_en !== 4'b0000 || seg_bcd !== 4'h0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got en=%b seg=%h fd=%b want en=0000 seg=0 fd=0",
                     digit_en, seg_bcd, frame_done);
        end
        rst_n = 1'b1;
        cyc   = -1;
        check_frame("idle_f0", 16'h0000, 4'b1111, 31);
        check_frame("idle_f1", 16'h0000, 4'b1111, 31);
    endtask

    task automatic test_load_1234();
        lz_blank = 1'b0;
        apply_reset();
        tick();
        value = 16'h1234;
        load  = 1'b1;
        check_frame("l1234_f0", 16'h0000, 4'b1111, 31);
        check_frame("l1234_f1", 16'h1234, 4'b1111, 31);
    endtask

    task automatic test_lz_blank();
        lz_blank = 1'b1;
        apply_reset();
        tick();
        value = 16'h0007;
        load  = 1'b1;
        check_frame("lz_f0", 16'h0000, 4'b0001, 31);
        check_frame("lz_f1", 16'h0007, 4'b0001, 31);
        lz_blank = 1'b0;
        check_frame("nolz_f2", 16'h0007, 4'b1111, 31);
    endtask

    task automatic test_midframe_and_boundary();
        lz_blank = 1'b0;
        apply_reset();
        tick();
        value = 16'h1234;
        load  = 1'b1;
        check_frame("mid_f0", 16'h0000, 4'b1111, 31);
        check_frame("mid_f1a", 16'h1234, 4'b1111, 10);
        value = 16'h5678;
        load  = 1'b1;
        check_frame("mid_f1b", 16'h1234, 4'b1111, 31);
        check_frame("mid_f2", 16'h5678, 4'b1111, 31);
        value = 16'h4321;
        load  = 1'b1;
        check_frame("bnd_f3a", 16'h4321, 4'b1111, 5);
        value = 16'h1111;
        load  = 1'b1;
        check_frame("bnd_f3b", 16'h4321, 4'b1111, 6);
        value = 16'h2222;
        load  = 1'b1;
        check_frame("bnd_f3c", 16'h4321, 4'b1111, 31);
        check_frame("lastwins_f4", 16'h2222, 4'b1111, 31);
    endtask

    task automatic test_dash();
        lz_blank = 1'b1;
        apply_reset();
        tick();
        value = 16'h00A0;
        load  = 1'b1;
        check_frame("dash_f0", 16'h0000, 4'b0001, 31);
        check_frame("dash_f1", 16'h00A0, 4'b0011, 31);
    endtask

    task automatic test_reset_midslot();
        lz_blank = 1'b0;
        apply_reset();
        tick();
        value = 16'h1234;
        load  = 1'b1;
        check_frame("rmid_f0", 16'h0000, 4'b1111, 31);
        check_frame("rmid_f1", 16'h1234, 4'b1111, 19);
        rst_n = 1'b0;
        #1;
        total++;
        if (digit_en !== 4'b0000 || seg_bcd !== 4'h0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL rst_midslot got en=%b seg=%h fd=%b want en=0000 seg=0 fd=0",
                     digit_en, seg_bcd, frame_done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = -1;
        check_frame("rmid_after0", 16'h0000, 4'b1111, 31);
        check_frame("rmid_after1", 16'h0000, 4'b1111, 31);
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        lz_blank = 1'b0;
        test_reset();
        test_load_1234();
        test_lz_blank();
        test_midframe_and_boundary();
        test_dash();
        test_reset_midslot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
